// File: rtl/row_requantize_activation.sv
// Requantizes a packed row of 2W-bit dot products to W bits, one element per cycle.
// Optional ReLU on the outputs when ROW_REQUANT_RELU_EN is defined.
module row_requantize_activation #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int FRAC = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*D*W-1:0]   packed_in,
  input  logic               in_v,
  output logic [D*W-1:0]     packed_out,
  output logic               out_v,
  output logic               out_sat,
  output logic               overrun
);

  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

  localparam logic signed [2*W:0] HALF  = {{(2*W){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [2*W:0] MAX_S = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_S = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]        MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        MIN_W = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [2*D*W-1:0]     in_q, in_d;
  logic [D*W-1:0]       shadow_q, shadow_d;
  logic                 row_sat_q, row_sat_d;
  logic [D*W-1:0]       out_q, out_d;
  logic                 out_v_q, out_v_d;
  logic                 out_sat_q, out_sat_d;
  logic                 overrun_q, overrun_d;

  int                   elem_pos;
  logic signed [2*W-1:0] elem;
  logic signed [2*W:0]  ext;
  logic signed [2*W:0]  rounded;
  logic signed [2*W:0]  shifted;
  logic [W-1:0]         elem_res;
  logic                 elem_sat;

  // Shared round/shift/saturate datapath; the guard bit keeps the rounding add exact.
  always_comb begin
    elem_pos = D - 1 - int'(idx_q);
    elem     = in_q[elem_pos*2*W +: 2*W];
    ext      = {elem[2*W-1], elem};
    rounded  = ext + HALF;
    shifted  = rounded >>> FRAC;
    elem_sat = 1'b0;
    if (shifted > MAX_S) begin
      elem_res = MAX_W;
      elem_sat = 1'b1;
    end else if (shifted < MIN_S) begin
      elem_res = MIN_W;
      elem_sat = 1'b1;
    end else begin
      elem_res = shifted[W-1:0];
    end
`ifdef ROW_REQUANT_RELU_EN
    if (elem_res[W-1]) elem_res = '0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_d      = in_q;
    shadow_d  = shadow_q;
    row_sat_d = row_sat_q;
    out_d     = out_q;
    out_v_d   = 1'b0;
    out_sat_d = out_sat_q;
    overrun_d = overrun_q;
    case (state_q)
      BUSY: begin
        shadow_d[elem_pos*W +: W] = elem_res;
        row_sat_d = row_sat_q | elem_sat;
        if (in_v) overrun_d = 1'b1;
        // The last element lands straight in the output so out_v follows D+1 cycles after in_v.
        if (idx_q == LAST_IDX) begin
          out_d     = shadow_d;
          out_sat_d = row_sat_q | elem_sat;
          out_v_d   = 1'b1;
          state_d   = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        if (in_v) begin
          in_d      = packed_in;
          shadow_d  = '0;
          row_sat_d = 1'b0;
          idx_d     = '0;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      in_q      <= '0;
      shadow_q  <= '0;
      row_sat_q <= 1'b0;
      out_q     <= '0;
      out_v_q   <= 1'b0;
      out_sat_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_q      <= in_d;
      shadow_q  <= shadow_d;
      row_sat_q <= row_sat_d;
      out_q     <= out_d;
      out_v_q   <= out_v_d;
      out_sat_q <= out_sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign packed_out = out_q;
  assign out_v      = out_v_q;
  assign out_sat    = out_sat_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/row_requantize_activation.md
Name: row_requantize_activation

Overview:
- Consumes one packed row of 2W-wide dot-product results, as produced by a row-by-matrix multiply stage.
- Requantizes each element back to W bits by rounding, arithmetic shift and saturation.
- Emits a packed W-wide row with a single-cycle valid, ready to feed the next layer's packed_a input.
- Processes one element per cycle to share a single round/saturate datapath across the row.

Parameters:
- W, 16: output element width; input elements are 2*W wide.
- D, 8: number of elements per row.
- FRAC, 12: fractional bits to drop (right-shift amount); 1 <= FRAC < 2*W.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous and active-high.
- packed_in  input  2*D*W  signed; element j occupies bits [(D-j)*2W-1 : (D-j-1)*2W], so element 0 is at the MSBs.
- in_v  input  1  one-cycle pulse; packed_in is valid this cycle.
- packed_out  output  D*W  signed; element j occupies bits [(D-j)*W-1 : (D-j-1)*W].
- out_v  output  1  one-cycle pulse; packed_out holds a new row.
- out_sat  output  1  valid with out_v; 1 if any element of that row saturated.
- overrun  output  1  sticky; set when in_v arrives while the block is busy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - packed_out=0, out_v=0, out_sat=0, overrun=0, state=IDLE, idx=0, shadow row=0.
  - Reset has priority over every other event, including mid-row: the in-flight row is discarded and no out_v follows.
- State machine: IDLE, BUSY, DONE.
  - IDLE: in_v=1 captures packed_in into the input register, clears the shadow row and the row-saturation flag, sets idx=0, moves to BUSY. in_v=0: stay.
  - BUSY: each cycle processes element idx into shadow slot idx and ORs its saturation into the row flag. If idx==D-1, go to DONE; otherwise idx++.
  - DONE (one cycle): packed_out<=shadow, with the final element's value and saturation folded in. out_v=1, out_sat=row flag. Go to IDLE.
    - in_v=1 in DONE is accepted: the row is captured and the state goes to BUSY directly, not IDLE.
  - in_v=1 in BUSY is ignored and sets overrun=1. overrun clears only on rst.
- Latency: in_v at cycle 0 gives out_v at cycle D+1. Maximum throughput is one row per D+1 cycles.
- packed_out and out_sat hold their value between out_v pulses. out_sat is meaningful only with out_v.
- Per-element arithmetic:
  - Sign-extend x to 2W+1 bits.
  - t = x + 2^(FRAC-1), giving round-half-up toward +inf.
  - s = t >>> FRAC, an arithmetic shift.
  - If s > 2^(W-1)-1, output 2^(W-1)-1 and flag saturation.
  - If s < -2^(W-1), output -2^(W-1) and flag saturation.
  - Otherwise output s[W-1:0].
- No overflow is possible in the rounding add because of the one extra guard bit.
- out_v and in_v may coincide in the same cycle; both take effect.

Optional Feature:
- Macro: ROW_REQUANT_RELU_EN.
- Defined: after saturation, any negative element is replaced by 0. The saturation flag is still set for negative overflow before ReLU, so a row whose only saturation was negative reports out_sat=1 with output 0.
- Undefined: elements are signed requantized values with no activation applied.

Test Plan:
- W=16, FRAC=12, D=4; in_v with elements {16777216, -16777216, 2048, 2047} -> out_v exactly 5 cycles later, packed_out={4096, -4096, 1, 0}, out_sat=0.
- Elements {0x7FFFFFFF, 0x80000000, -2048, -2049} -> {32767, -32768, 0, -1}, out_sat=1. With ROW_REQUANT_RELU_EN: {32767, 0, 0, 0}, out_sat=1.
- Row A accepted; in_v with row B two cycles later (BUSY) -> one out_v carrying row A only, overrun=1 and stays 1 until rst.
- Row A, then row B with in_v asserted in A's out_v cycle -> B accepted, second out_v 5 cycles after the first, overrun=0.
- rst asserted on the 2nd BUSY cycle -> no out_v; packed_out=0, out_sat=0, overrun=0. A fresh row afterwards completes normally after 5 cycles.
- Idle hold: after an out_v, 20 cycles with in_v=0 -> out_v stays 0 and packed_out is unchanged.
